// File: rtl/adc_scan_scheduler_if.sv
// Handshake and sample bus between the ADC front end, the scan scheduler and its consumers.
// The scheduler connects through the slave modport; the master modport is the surrounding system.
interface adc_scan_scheduler_if;
    logic        run;
    logic [15:0] en_mask;
    logic [3:0]  channel;
    logic        new_sample;
    logic [9:0]  sample;
    logic [3:0]  sample_channel;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_sample;
    logic [3:0]  out_channel;
    logic        timeout_err;
    logic        busy;

    modport master (
        output run, en_mask, new_sample, sample, sample_channel, out_ready,
        input  channel, out_valid, out_sample, out_channel, timeout_err, busy
    );

    modport slave (
        input  run, en_mask, new_sample, sample, sample_channel, out_ready,
        output channel, out_valid, out_sample, out_channel, timeout_err, busy
    );
endinterface

// File: rtl/adc_scan_scheduler.sv
// Round-robin ADC channel sequencer: settle, drop the stale sample, capture, hand off with channel tag.
// Optional macro ADC_SCAN_AVERAGE_EN: capture averages four consecutive matching samples.
module adc_scan_scheduler #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                 clk,
    input logic                 rst,
    adc_scan_scheduler_if.slave bus
);
    typedef enum logic [2:0] {IDLE, NEXT, SWITCH, DISCARD, CAPTURE, OUTPUT} state_t;

    state_t      state;
    logic [3:0]  last_ch;
    logic [3:0]  channel_r;
    logic [7:0]  settle_cnt;
    logic [15:0] tmo_cnt;
    logic        out_valid_r;
    logic [9:0]  out_sample_r;
    logic [3:0]  out_channel_r;
    logic        timeout_err_r;
    logic        match;
    logic        tmo_hit;
    logic        cap_fire;
    logic [9:0]  cap_value;
    logic [3:0]  sel_ch;

    // Lowest rotation distance wins; distance 16 wraps back to the previous channel itself.
    function automatic logic [3:0] pick_next(input logic [15:0] mask, input logic [3:0] from);
        logic [3:0] idx;
        logic [3:0] res;
        res = from;
        for (int i = 16; i >= 1; i--) begin
            idx = from + 4'(i);
            if (mask[idx]) res = idx;
        end
        return res;
    endfunction

    assign match   = bus.new_sample && (bus.sample_channel == channel_r);
    assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign sel_ch  = pick_next(bus.en_mask, last_ch);

`ifdef ADC_SCAN_AVERAGE_EN
    logic [11:0] acc;
    logic [1:0]  acc_cnt;
    logic [11:0] acc_sum;

    function automatic logic [9:0] avg4(input logic [11:0] s);
        return s[11:2];
    endfunction

    assign acc_sum   = acc + {2'b00, bus.sample};
    assign cap_fire  = match && (acc_cnt == 2'd3);
    assign cap_value = avg4(acc_sum);
`else
    assign cap_fire  = match;
    assign cap_value = bus.sample;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_ch       <= 4'd15;
            channel_r     <= 4'd0;
            settle_cnt    <= 8'd0;
            tmo_cnt       <= 16'd0;
            out_valid_r   <= 1'b0;
            out_sample_r  <= 10'd0;
            out_channel_r <= 4'd0;
            timeout_err_r <= 1'b0;
`ifdef ADC_SCAN_AVERAGE_EN
            acc           <= 12'd0;
            acc_cnt       <= 2'd0;
`endif
        end else begin
            timeout_err_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.run && (bus.en_mask != 16'd0)) state <= NEXT;
                end
                NEXT: begin
                    if (bus.en_mask == 16'd0) begin
                        state <= IDLE;
                    end else begin
                        channel_r  <= sel_ch;
                        last_ch    <= sel_ch;
                        settle_cnt <= 8'd0;
                        state      <= SWITCH;
                    end
`ifdef ADC_SCAN_AVERAGE_EN
                    acc     <= 12'd0;
                    acc_cnt <= 2'd0;
`endif
                end
                SWITCH: begin
                    if (settle_cnt == 8'(SETTLE_CYCLES - 1)) begin
                        tmo_cnt <= 16'd0;
                        state   <= DISCARD;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                // One timeout window spans both the discard and the capture phase.
                DISCARD, CAPTURE: begin
                    if ((state == CAPTURE) && cap_fire) begin
                        out_sample_r  <= cap_value;
                        out_channel_r <= channel_r;
                        out_valid_r   <= 1'b1;
                        state         <= OUTPUT;
                    end else if (tmo_hit) begin
                        timeout_err_r <= 1'b1;
                        if (bus.run) state <= NEXT;
                        else         state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                        if ((state == DISCARD) && match) state <= CAPTURE;
                    end
`ifdef ADC_SCAN_AVERAGE_EN
                    if ((state == CAPTURE) && match) begin
                        acc     <= acc_sum;
                        acc_cnt <= acc_cnt + 2'd1;
                    end
`endif
                end
                OUTPUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        if (bus.run) state <= NEXT;
                        else         state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.channel     = channel_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_sample  = out_sample_r;
    assign bus.out_channel = out_channel_r;
    assign bus.timeout_err = timeout_err_r;
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Randomized bench for adc_scan_scheduler against an epoch-timing reference model.
// Builds with or without ADC_SCAN_AVERAGE_EN; the model follows the same macro.
module tb_adc_scan_scheduler;
    localparam int S = 3;
    localparam int T = 16;
`ifdef ADC_SCAN_AVERAGE_EN
    localparam int NEED = 5;
`else
    localparam int NEED = 2;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adc_scan_scheduler_if bus();

    adc_scan_scheduler #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: an epoch is one channel visit, timed from the edge its channel is selected.
    int k        = 0;
    bit m_idle   = 1'b1;
    bit m_hold   = 1'b0;
    int sel_at   = -1;
    int ep_start = -1000;
    int seen     = 0;
    int sum      = 0;
    int m_last   = 15;
    int m_ch     = 0;
    bit m_ov     = 1'b0;
    int m_osmp   = 0;
    int m_och    = 0;
    bit m_te     = 1'b0;
    int n_te     = 0;
    int dut_te   = 0;

    function automatic int rr_next(input int from, input logic [15:0] mask);
        for (int d = 1; d <= 16; d++)
            if (mask[(from + d) % 16]) return (from + d) % 16;
        return from;
    endfunction

    task automatic end_epoch();
        if (bus.run) sel_at = k + 1;
        else         m_idle = 1'b1;
    endtask

    task automatic model_edge();
        bit got;
        k++;
        m_te = 1'b0;
        if (rst) begin
            m_idle = 1'b1; m_hold = 1'b0; m_last = 15; m_ch = 0;
            m_ov = 1'b0; m_osmp = 0; m_och = 0; sel_at = -1; ep_start = -1000;
        end else if (m_idle) begin
            if (bus.run && (bus.en_mask != 16'd0)) begin
                m_idle = 1'b0;
                sel_at = k + 1;
            end
        end else if (k == sel_at) begin
            if (bus.en_mask == 16'd0) begin
                m_idle = 1'b1;
            end else begin
                m_ch = rr_next(m_last, bus.en_mask);
                m_last = m_ch; ep_start = k; seen = 0; sum = 0;
            end
        end else if (m_hold) begin
            if (bus.out_ready) begin
                m_hold = 1'b0;
                m_ov   = 1'b0;
                end_epoch();
            end
        end else if (k > ep_start + S) begin
            got = 1'b0;
            if (bus.new_sample && (int'(bus.sample_channel) == m_ch)) begin
                seen++;
                if (seen >= 2) sum += int'(bus.sample);
                if (seen == NEED) begin
                    got = 1'b1; m_hold = 1'b1; m_ov = 1'b1; m_och = m_ch;
                    m_osmp = (NEED == 2) ? sum : sum / 4;
                end
            end
            if (!got && (k == ep_start + S + T)) begin
                m_te = 1'b1;
                n_te++;
                end_epoch();
            end
        end
    endtask

    task automatic compare();
        if (bus.timeout_err === 1'b1) dut_te++;
        chk("busy",        32'(bus.busy),        32'(!m_idle));
        chk("channel",     32'(bus.channel),     32'(m_ch));
        chk("out_valid",   32'(bus.out_valid),   32'(m_ov));
        chk("out_sample",  32'(bus.out_sample),  32'(m_osmp));
        chk("out_channel", 32'(bus.out_channel), 32'(m_och));
        chk("timeout_err", 32'(bus.timeout_err), 32'(m_te));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic drive_adc(input int pct, input bit skip3, input bit fixed_data);
        logic [3:0] c;
        bus.new_sample = ($urandom_range(99) < pct);
        c = ($urandom_range(99) < 80) ? bus.channel : 4'($urandom_range(15));
        if (skip3 && (c == 4'd3)) c = 4'd5;
        bus.sample_channel = c;
        bus.sample = fixed_data ? 10'(16'h100 + 16'(c)) : 10'($urandom_range(1023));
    endtask

    task automatic run_phase(input int n, input int pct, input bit skip3, input bit fixed_data,
                             input int ready_pct);
        for (int i = 0; i < n; i++) begin
            cycle();
            drive_adc(pct, skip3, fixed_data);
            bus.out_ready = ($urandom_range(99) < ready_pct);
        end
    endtask

    task automatic drain_to_idle(input string tag);
        int budget;
        bus.run = 1'b0;
        budget = 300;
        while ((bus.busy === 1'b1) && (budget > 0)) begin
            run_phase(1, 60, 1'b0, 1'b0, 100);
            budget--;
        end
        chk(tag, 32'(bus.busy), 32'd0);
    endtask

    int te0;
    int dte0;
    int budget;

    initial begin
        rst = 1'b1;
        bus.run = 1'b0; bus.en_mask = 16'd0; bus.new_sample = 1'b0;
        bus.sample = 10'd0; bus.sample_channel = 4'd0; bus.out_ready = 1'b0;
        repeat (3) cycle();
        rst = 1'b0;

        // ch0/ch2 alternation with tagged ADC data
        bus.en_mask = 16'h0005; bus.run = 1'b1;
        run_phase(300, 60, 1'b0, 1'b1, 100);

        // wrap-around between ch15 and ch0
        bus.en_mask = 16'h8001;
        run_phase(200, 60, 1'b0, 1'b0, 100);

        // empty mask with run held high
        bus.en_mask = 16'h0000;
        run_phase(80, 60, 1'b0, 1'b0, 100);
        chk("empty_mask_idle", 32'(bus.busy), 32'd0);

        // long back-pressure with samples still arriving
        bus.en_mask = 16'h00F0;
        run_phase(100, 60, 1'b0, 1'b0, 70);
        run_phase(60, 70, 1'b0, 1'b0, 0);
        run_phase(60, 60, 1'b0, 1'b0, 100);

        // silent channel 3: repeated timeouts
        te0 = n_te; dte0 = dut_te;
        bus.en_mask = 16'h0008;
        run_phase(150, 70, 1'b1, 1'b0, 100);
        chk("timeout_count", 32'(dut_te - dte0), 32'(n_te - te0));
        chk("timeouts_seen", 32'(dut_te - dte0 >= 5), 32'd1);

        // run dropped during settle on ch1
        drain_to_idle("drain_busy");
        bus.en_mask = 16'h0002; bus.run = 1'b1;
        run_phase(3, 60, 1'b0, 1'b0, 100);
        bus.run = 1'b0;
        run_phase(60, 60, 1'b0, 1'b0, 100);
        chk("stop_idle", 32'(bus.busy), 32'd0);

        // randomized masks, run toggling, mixed back-pressure
        for (int r = 0; r < 40; r++) begin
            bus.en_mask = ($urandom_range(7) == 0) ? 16'h0000 : 16'($urandom);
            bus.run = ($urandom_range(3) != 0);
            run_phase(30, 60, 1'b0, 1'b0, 70);
        end

        // reset while a result is pending
        bus.en_mask = 16'h0024; bus.run = 1'b1;
        budget = 500;
        while ((bus.out_valid !== 1'b1) && (budget > 0)) begin
            run_phase(1, 60, 1'b0, 1'b0, 0);
            budget--;
        end
        chk("wait_out_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        cycle();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_channel",   32'(bus.channel),   32'd0);
        rst = 1'b0;
        run_phase(120, 60, 1'b0, 1'b0, 80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/adc_scan_scheduler.md
Name: adc_scan_scheduler

Overview:
- Round-robin sequencer for the shared 10-bit ADC front end.
- Selects the next enabled analog channel and waits for the converter to settle.
- Discards the first (stale) sample after each switch, captures the next matching sample, and presents it on a valid/ready output with its channel tag.
- Sits between the ADC interface and downstream consumers (PWM/LED display, UART logger); replaces hard-wired single-channel selection.

Parameters:
- SETTLE_CYCLES, 4: clk cycles to hold in SWITCH after channel changes, before samples are considered; range 1..255.
- TIMEOUT_CYCLES, 4096: max clk cycles spent waiting in DISCARD+CAPTURE for one channel before skipping it; range 2..65535.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high; clock clk
- run  in  1  level; 1 = keep scanning, 0 = finish current channel then idle
- en_mask  in  16  bit i enables analog channel i
- channel  out  4  channel select to ADC interface
- new_sample  in  1  one-cycle strobe from ADC interface
- sample  in  10  conversion result, valid with new_sample
- sample_channel  in  4  channel of sample, valid with new_sample
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_sample  out  10  captured result
- out_channel  out  4  channel of out_sample
- timeout_err  out  1  one-cycle pulse when a channel is skipped on timeout
- busy  out  1  1 in any state except IDLE

Behaviour:
- Reset values: channel=0, out_valid=0, out_sample=0, out_channel=0, timeout_err=0, busy=0, state=IDLE, all counters 0, last channel register=15 so the first scan starts at channel 0.
- Next-channel search (NEXT): rotate from last+1 upward, wrapping 15->0; pick the first set bit of en_mask, sampled in that cycle. If only the last channel is enabled, it is reselected. If en_mask==0, go to IDLE.
- States:
  - IDLE: busy=0. When run=1 and en_mask!=0, go to NEXT.
  - NEXT: 1 cycle. Register the selected channel onto the channel output and into last; clear the settle counter; go to SWITCH.
  - SWITCH: count SETTLE_CYCLES cycles, ignoring new_sample throughout; then go to DISCARD and clear the timeout counter.
  - DISCARD: the first new_sample with sample_channel==channel is dropped; go to CAPTURE. The timeout counter keeps running across DISCARD and CAPTURE (not cleared).
  - CAPTURE: the first new_sample with sample_channel==channel loads out_sample=sample and out_channel=channel, sets out_valid=1 next cycle; go to OUTPUT.
  - OUTPUT: hold out_valid/out_sample/out_channel stable until out_valid&out_ready. On handshake, clear out_valid; go to NEXT if run=1, otherwise IDLE.
- Non-matching new_sample: ignored in every state.
- Timeout: if the counter reaches TIMEOUT_CYCLES-1 in DISCARD or CAPTURE without a capture, pulse timeout_err for 1 cycle and go to NEXT (or IDLE if run=0). No output is produced for that channel.
- Capture and timeout expiry in the same cycle: capture wins and no timeout_err pulse is issued.
- Stopping: run deasserted mid-channel does not abort; the current channel completes (capture+handshake or timeout), then IDLE.
- Mask changes: take effect only at the next NEXT; the channel in progress is not aborted.
- Latency: from matching new_sample in CAPTURE to out_valid=1 is 1 cycle. Minimum per-channel time = 1 (NEXT) + SETTLE_CYCLES + two conversions + 1 + handshake.
- Reset mid-operation: immediate return to reset values. A pending out_valid is dropped without handshake.

Optional Feature:
- Macro: ADC_SCAN_AVERAGE_EN.
- Defined: CAPTURE accumulates 4 consecutive matching samples into a 12-bit sum, then out_sample = sum[11:2] (truncating). The timeout still covers the whole DISCARD+CAPTURE window. The accumulator is cleared in NEXT.
- Undefined: a single matching sample is captured as described above; no accumulator logic is present.

Test Plan:
- Mask 0x0005, run=1, ADC model returns 0x100+ch, out_ready=1 -> outputs alternate ch0=0x100, ch2=0x102; channel never drives 1; first sample after each switch is discarded.
- Mask 0x8001 with last=0 -> selection order 15, 0, 15 (wrap-around); en_mask=0 with run=1 -> busy stays 0.
- out_ready held 0 for 50 cycles in OUTPUT with further new_samples arriving -> out_valid, out_sample, out_channel remain stable; no new capture occurs.
- ADC model never answers channel 3 (mask 0x0008), TIMEOUT_CYCLES=16 -> timeout_err pulses exactly once per scan attempt, out_valid stays 0, scheduler reselects ch3.
- run dropped during SWITCH for ch1 -> ch1 still captured and handshaken, then busy=0 and state IDLE; rst asserted while out_valid=1 -> out_valid=0 the next cycle and channel=0.
- With ADC_SCAN_AVERAGE_EN, samples 10, 11, 12, 14 on ch0 -> out_sample=11.
